// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// Latency/backpressure: none here (types, constants and a pure byte-merge function).
package ram_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int RD_FIRST   = 0;
   localparam int WR_FIRST   = 1;

   // Widest word the merge helper handles; callers size-cast to their own width.
   localparam int MAX_DATA_W = 512;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_array_core.sv
// Byte-lane storage array with one synchronous read/write port and no reset; read data 1 cycle after re.
// No backpressure: every cycle with we/re is performed; q holds when re is low.
module ram_array_core
   import ram_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 9,
   parameter int RD_MODE = RD_FIRST
) (
   input  logic                CLK,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdat,
   input  logic                re,
   output logic [DATA_W-1:0]   q
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] q_old;
   logic [DATA_W-1:0] wdat_d;
   logic [NB-1:0]     be_d;
   logic              wr_d;

   // One bank per byte lane keeps each bank a plain read-first RAM.
   for (genvar i = 0; i < NB; i++) begin : g_lane
      logic [7:0] bank [DEPTH];
      logic [7:0] q_lane;

      always_ff @(posedge CLK) begin
         if (we && be[i]) begin
            bank[addr] <= wdat[8*i +: 8];
         end
         if (re) begin
            q_lane <= bank[addr];
         end
      end

      assign q_old[8*i +: 8] = q_lane;
   end

   always_ff @(posedge CLK) begin
      if (re) begin
         wr_d   <= we;
         be_d   <= be;
         wdat_d <= wdat;
      end
   end

   // Write-first is rebuilt after the bank from the captured write, so the banks stay read-first.
   always_comb begin
      q = q_old;
      if (RD_MODE == WR_FIRST && wr_d) begin
         q = DATA_W'(byte_merge(MAX_DATA_W'(q_old), MAX_DATA_W'(wdat_d), MAX_BE_W'(be_d)));
      end
   end

endmodule

// File: rtl/ram_sp_param.sv
// Single-port RAM with byte enables, read-during-write mode, optional output register and clear engine; read latency 1 (OREG=0) or 2 (OREG=1).
// While BUSY (clear sweep) user accesses are dropped, not stalled; INIT beats a same-cycle access.
module ram_sp_param
   import ram_pkg::*;
#(
   parameter int               DATA_W         = 16,
   parameter int               ADDR_W         = 9,
   parameter int               OREG           = 0,
   parameter int               RD_MODE        = RD_FIRST,
   parameter int               CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CEN,
   input  logic                WEN,
   input  logic [DATA_W/8-1:0] BE,
   input  logic [ADDR_W-1:0]   A,
   input  logic [DATA_W-1:0]   D,
   output logic [DATA_W-1:0]   Q,
   output logic                Q_VALID,
   input  logic                INIT,
   output logic                BUSY
);

   localparam int     NB     = DATA_W / 8;
   localparam state_t ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              busy_q;
   logic              clr_we;
   logic              acc;
   logic              vld1;

   logic              arr_we;
   logic [NB-1:0]     arr_be;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdat;
   logic [DATA_W-1:0] arr_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ST_RST;
         cnt    <= '0;
         busy_q <= (ST_RST == ST_CLEAR);
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         busy_q <= (state_nxt == ST_CLEAR);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (INIT) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (INIT) begin
               cnt_nxt = '0;
            end else if (cnt == {ADDR_W{1'b1}}) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ADDR_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign BUSY = busy_q;

   // The clear engine owns the port for the whole sweep.
   assign acc      = CEN && (state == ST_IDLE) && !INIT;
   assign arr_we   = clr_we || (acc && WEN);
   assign arr_be   = clr_we ? {NB{1'b1}} : BE;
   assign arr_addr = clr_we ? cnt : A;
   assign arr_wdat = clr_we ? INIT_VALUE : D;

   ram_array_core #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RD_MODE (RD_MODE)
   ) u_core (
      .CLK  (CLK),
      .we   (arr_we),
      .be   (arr_be),
      .addr (arr_addr),
      .wdat (arr_wdat),
      .re   (acc),
      .q    (arr_q)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld1 <= 1'b0;
      end else begin
         vld1 <= acc && !WEN;
      end
   end

   if (OREG != 0) begin : g_oreg
      logic              upd1;
      logic              vld2;
      logic [DATA_W-1:0] q_r;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            upd1 <= 1'b0;
            vld2 <= 1'b0;
            q_r  <= '0;
         end else begin
            upd1 <= acc;
            vld2 <= vld1;
            if (upd1) begin
               q_r <= arr_q;
            end
         end
      end

      assign Q       = q_r;
      assign Q_VALID = vld2;
   end else begin : g_noreg
      // The array read register has no reset; mask it until the first access lands.
      logic loaded;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            loaded <= 1'b0;
         end else if (acc) begin
            loaded <= 1'b1;
         end
      end

      assign Q       = loaded ? arr_q : '0;
      assign Q_VALID = vld1;
   end

endmodule
